vector_execute_unit: RTL and testbench

//  Lane-wise vector ALU that consumes the two source operands read from the
//  16x32 vector register file. It returns the result to the register file's

---
 rtl/vector_pkg.sv | 27 ++
 rtl/vector_lane_alu.sv | 35 +++
 rtl/vector_execute_unit.sv | 112 +++++++++++
 tb/tb_vector_execute_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared constants for the vector datapath: lane geometry, register index
// width and the opcode encoding used by the decoder, register file and ALU.
package vector_pkg;

  localparam int LANES       = 4;
  localparam int LANE_WIDTH  = 8;
  localparam int INDEX_WIDTH = 4;
  localparam int VEC_WIDTH   = LANES * LANE_WIDTH;
  localparam int OP_WIDTH    = 3;
  localparam int LANE_CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [OP_WIDTH-1:0] OP_VADD  = 3'b000;
  localparam logic [OP_WIDTH-1:0] OP_VSUB  = 3'b001;
  localparam logic [OP_WIDTH-1:0] OP_VAND  = 3'b010;
  localparam logic [OP_WIDTH-1:0] OP_VOR   = 3'b011;
  localparam logic [OP_WIDTH-1:0] OP_VXOR  = 3'b100;
  localparam logic [OP_WIDTH-1:0] OP_VADDS = 3'b101;
  localparam logic [OP_WIDTH-1:0] OP_VMUL  = 3'b110;
  localparam logic [OP_WIDTH-1:0] OP_VMOV  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC_MUL = 2'd1,
    ST_WB       = 2'd2
  } state_t;

endpackage

// File: rtl/vector_lane_alu.sv
// Single-lane combinational ALU covering every opcode except VMUL, which is
// handled by the shared lane-serial multiplier in the top level.
module vector_lane_alu
  import vector_pkg::*;
(
  input  logic [OP_WIDTH-1:0]   opcode,
  input  logic [LANE_WIDTH-1:0] a,
  input  logic [LANE_WIDTH-1:0] b,
  output logic [LANE_WIDTH-1:0] y
);

  function automatic logic [LANE_WIDTH-1:0] sat_add(
    input logic [LANE_WIDTH-1:0] x,
    input logic [LANE_WIDTH-1:0] z
  );
    logic [LANE_WIDTH:0] sum;
    sum = {1'b0, x} + {1'b0, z};
    return sum[LANE_WIDTH] ? {LANE_WIDTH{1'b1}} : sum[LANE_WIDTH-1:0];
  endfunction

  always_comb begin
    y = '0;
    case (opcode)
      OP_VADD:  y = a + b;
      OP_VSUB:  y = a - b;
      OP_VAND:  y = a & b;
      OP_VOR:   y = a | b;
      OP_VXOR:  y = a ^ b;
      OP_VADDS: y = sat_add(a, b);
      OP_VMOV:  y = a;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/vector_execute_unit.sv
// Lane-wise vector ALU: simple ops write back one cycle after acceptance,
// VMUL walks the lanes through one shared multiplier before writing back.
module vector_execute_unit
  import vector_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_WIDTH-1:0]    opcode,
  input  logic [VEC_WIDTH-1:0]   source1,
  input  logic [VEC_WIDTH-1:0]   source2,
  input  logic [INDEX_WIDTH-1:0] index_vd,
  output logic                   update_enable,
  output logic [VEC_WIDTH-1:0]   update_register,
  output logic [INDEX_WIDTH-1:0] update_index,
  output logic                   busy
);

  state_t                 state, state_next;
  logic [LANE_CNT_W-1:0]  lane;
  logic                   lane_last;
  logic                   accept;
  logic [VEC_WIDTH-1:0]   alu_result;
  logic [VEC_WIDTH-1:0]   src1_q, src2_q, acc, acc_next;
  logic [INDEX_WIDTH-1:0] vd_q;
  logic [LANE_WIDTH-1:0]  mul_a, mul_b;
  logic [2*LANE_WIDTH-1:0] mul_prod;

  // Acceptance stage: simple ops are evaluated straight from the operands
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vector_lane_alu u_alu (
      .opcode (opcode),
      .a      (source1[g*LANE_WIDTH +: LANE_WIDTH]),
      .b      (source2[g*LANE_WIDTH +: LANE_WIDTH]),
      .y      (alu_result[g*LANE_WIDTH +: LANE_WIDTH])
    );
  end

  assign accept    = in_valid && (state == ST_IDLE);
  assign lane_last = (lane == LANE_CNT_W'(LANES - 1));

  // Multiply stage: one lane per cycle, only the low lane bits are kept
  assign mul_a    = src1_q[lane*LANE_WIDTH +: LANE_WIDTH];
  assign mul_b    = src2_q[lane*LANE_WIDTH +: LANE_WIDTH];
  assign mul_prod = (2*LANE_WIDTH)'(mul_a) * (2*LANE_WIDTH)'(mul_b);

  always_comb begin
    acc_next = acc;
    acc_next[lane*LANE_WIDTH +: LANE_WIDTH] = mul_prod[LANE_WIDTH-1:0];
  end

  always_comb begin
    state_next    = state;
    in_ready      = 1'b0;
    busy          = 1'b0;
    update_enable = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (accept) state_next = (opcode == OP_VMUL) ? ST_EXEC_MUL : ST_WB;
      end
      ST_EXEC_MUL: begin
        busy = 1'b1;
        if (lane_last) state_next = ST_WB;
      end
      ST_WB: begin
        busy          = 1'b1;
        update_enable = 1'b1;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Writeback registers only change on entry to WB so they hold afterwards
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      lane            <= '0;
      update_register <= '0;
      update_index    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        lane <= '0;
        if (opcode != OP_VMUL) begin
          update_register <= alu_result;
          update_index    <= index_vd;
        end
      end else if (state == ST_EXEC_MUL) begin
        lane <= lane_last ? '0 : lane + 1'b1;
        if (lane_last) begin
          update_register <= acc_next;
          update_index    <= vd_q;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      src1_q <= source1;
      src2_q <= source2;
      vd_q   <= index_vd;
      acc    <= '0;
    end else if (state == ST_EXEC_MUL) begin
      acc <= acc_next;
    end
  end

endmodule

// File: tb/tb_vector_execute_unit.sv
// Bench for vector_execute_unit: directed cases plus a random opcode sweep,
// all checked every cycle against a cycle-accurate transaction model.
module tb_vector_execute_unit;
  import vector_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  opcode = '0;
  logic [31:0] source1 = '0;
  logic [31:0] source2 = '0;
  logic [3:0]  index_vd = '0;
  logic        update_enable;
  logic [31:0] update_register;
  logic [3:0]  update_index;
  logic        busy;

  int total = 0;
  int bad   = 0;

  vector_execute_unit dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .opcode          (opcode),
    .source1         (source1),
    .source2         (source2),
    .index_vd        (index_vd),
    .update_enable   (update_enable),
    .update_register (update_register),
    .update_index    (update_index),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
    int          due;
  } wr_t;

  wr_t         exp_q[$];
  int          cyc = 0;
  int          next_free = 0;
  logic [31:0] last_reg = '0;
  logic [3:0]  last_idx = '0;
  logic        prev_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-lane arithmetic straight from the opcode table
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] s1,
                                         input logic [31:0] s2);
    logic [31:0] r;
    int a, b, v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a = int'((s1 >> (8*i)) & 32'hFF);
      b = int'((s2 >> (8*i)) & 32'hFF);
      case (op)
        OP_VADD:  v = (a + b) % 256;
        OP_VSUB:  v = (a - b + 256) % 256;
        OP_VAND:  v = a & b;
        OP_VOR:   v = a | b;
        OP_VXOR:  v = a ^ b;
        OP_VADDS: v = (a + b > 255) ? 255 : a + b;
        OP_VMUL:  v = (a * b) % 256;
        default:  v = a;
      endcase
      r = r | (32'(v) << (8*i));
    end
    return r;
  endfunction

  // Model and per-cycle compare
  initial begin
    wr_t w;
    logic exp_en;
    forever begin
      @(posedge clock);
      if (!reset_n) begin
        exp_q.delete();
        next_free = 0;
      end else if (in_valid && cyc >= next_free) begin
        w.data = ref_op(opcode, source1, source2);
        w.idx  = index_vd;
        w.due  = (opcode == OP_VMUL) ? cyc + LANES + 1 : cyc + 1;
        exp_q.push_back(w);
        next_free = w.due + 1;
      end
      cyc++;
      @(negedge clock);
      if (!reset_n) begin
        chk("rst_update_enable", {31'b0, update_enable}, 32'd0);
        chk("rst_update_register", update_register, 32'd0);
        chk("rst_update_index", {28'b0, update_index}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        exp_q.delete();
        next_free = 0;
        last_reg  = '0;
        last_idx  = '0;
        prev_en   = 1'b0;
      end else begin
        chk("in_ready", {31'b0, in_ready}, {31'b0, cyc >= next_free});
        chk("busy", {31'b0, busy}, {31'b0, cyc < next_free});
        exp_en = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("update_enable", {31'b0, update_enable}, {31'b0, exp_en});
        if (exp_en) begin
          last_reg = exp_q[0].data;
          last_idx = exp_q[0].idx;
          void'(exp_q.pop_front());
        end
        chk("update_register", update_register, last_reg);
        chk("update_index", {28'b0, update_index}, {28'b0, last_idx});
        total++;
        if (update_enable && prev_en) begin
          bad++;
          $display("FAIL double_strobe: update_enable high two cycles in a row (cycle %0d)", cyc);
        end
        prev_en = update_enable;
      end
    end
  end

  // Presents an op and returns just after the edge that accepted it,
  // leaving in_valid high for the caller to decide.
  task automatic issue(input logic [2:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [3:0] vd);
    logic r;
    bit   ok;
    opcode = op; source1 = s1; source2 = s2; index_vd = vd;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      r = in_ready;
      @(posedge clock);
      #1;
      if (r) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance within 20 cycles");
    end
  endtask

  task automatic wait_write(input logic [31:0] exp_data, input logic [3:0] exp_idx,
                            input string name, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      n++;
      if (update_enable) begin
        found = 1'b1;
        chk({name, "_data"}, update_register, exp_data);
        chk({name, "_index"}, {28'b0, update_index}, {28'b0, exp_idx});
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s_timeout: got no update_enable expected one within 20 cycles", name);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    issue(OP_VADD, 32'h01020304, 32'h10FF2030, 4'd3);
    in_valid = 1'b0;
    wait_write(32'h11012334, 4'd3, "vadd", n);
    chk("vadd_latency", 32'(n), 32'd1);

    issue(OP_VADDS, 32'hF0807F01, 32'h20807F01, 4'd5);
    in_valid = 1'b0;
    wait_write(32'hFFFFFE02, 4'd5, "vadds", n);
    issue(OP_VSUB, 32'hF0807F01, 32'h20807F01, 4'd6);
    in_valid = 1'b0;
    wait_write(32'hD0000000, 4'd6, "vsub", n);

    issue(OP_VMUL, 32'h02031011, 32'h03051010, 4'd7);
    in_valid = 1'b0;
    wait_write(32'h060F0010, 4'd7, "vmul", n);
    chk("vmul_latency", 32'(n), 32'd5);

    // Held request queued behind a VMUL
    issue(OP_VMUL, 32'h02031011, 32'h03051010, 4'd1);
    opcode = OP_VXOR; source1 = 32'hFFFF0000; source2 = 32'h0F0F0F0F; index_vd = 4'd2;
    issue(OP_VXOR, 32'hFFFF0000, 32'h0F0F0F0F, 4'd2);
    in_valid = 1'b0;
    wait_write(32'hF0F00F0F, 4'd2, "queued_vxor", n);
    repeat (3) @(posedge clock);
    #1;

    // Reset two cycles into a VMUL
    issue(OP_VMUL, 32'h11223344, 32'h55667788, 4'd9);
    in_valid = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(negedge clock);
    chk("abort_update_register", update_register, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("post_reset_no_strobe", {31'b0, update_enable}, 32'd0);
    end
    @(posedge clock);
    #1;

    // Random sweep over all opcodes
    for (int k = 0; k < 300; k++) begin
      issue(3'($urandom_range(0, 7)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) != 0) begin
        in_valid = 1'b0;
        opcode = 3'($urandom_range(0, 7));
        source1 = $urandom;
        source2 = $urandom;
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1;
      end
    end
    in_valid = 1'b0;
    repeat (10) @(negedge clock);
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
